decoder_scan_sequencer: RTL and testbench

//   Upstream driver for the 3-to-8 one-hot decoder: generates the 3-bit select

---
 rtl/decoder_scan_sequencer_if.sv | 31 +++
 rtl/decoder_scan_sequencer.sv | 139 +++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_sequencer_if.sv
// Control and select-code bundle between a scan controller (master) and the
// decoder_scan_sequencer (slave). Clock and reset stay outside as plain ports.
interface decoder_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    // Controls into the sequencer
    logic               start;
    logic               stop;
    logic               dir;
    logic               bounce;
    logic               loop;
    logic [DWELL_W-1:0] dwell;

    // Select code and strobes out of the sequencer
    logic               a;
    logic               b;
    logic               c;
    logic               active;
    logic               step;
    logic               done;

    modport master (
        output start, stop, dir, bounce, loop, dwell,
        input  a, b, c, active, step, done
    );

    modport slave (
        input  start, stop, dir, bounce, loop, dwell,
        output a, b, c, active, step, done
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Drives the {a,b,c} select code of a 3-to-8 one-hot decoder through a timed
// scan of the code range [FIRST, LAST]: up, down or bounce, single pass or
// looping, with each code held dwell+1 cycles. step marks every newly
// presented code, done marks the natural end of a single pass.
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int FIRST   = 0,
    parameter int LAST    = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_scan_sequencer_if.slave  bus
);

    localparam logic [2:0] C_FIRST    = 3'(FIRST);
    localparam logic [2:0] C_LAST     = 3'(LAST);
    localparam logic [2:0] C_FIRST_P1 = 3'(FIRST + 1);
    localparam logic [2:0] C_LAST_M1  = 3'(LAST - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    state_e             r_state;
    logic [2:0]         r_code;
    logic               r_active;
    logic               r_step;
    logic               r_done;
    logic [DWELL_W-1:0] r_cnt;

    // Scan configuration captured at start; mid-scan input changes are ignored.
    logic [DWELL_W-1:0] r_dwell;
    logic               r_down;     // current direction, 1 = counting down
    logic               r_bounce;
    logic               r_loop;
    logic               r_turned;   // a bounce reversal has happened this pass

    logic               w_dwell_done;
    logic               w_at_end;

    // Current code has been held for its full dwell time.
    assign w_dwell_done = (r_cnt == r_dwell);

    // Current code is the range end in the current direction of travel.
    assign w_at_end = r_down ? (r_code == C_FIRST) : (r_code == C_LAST);

    // Scan FSM: all outputs come straight from registers updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched configuration is reset along with the state so
            // every register has a known value; it is reloaded on each start.
            r_state  <= S_IDLE;
            r_code   <= 3'd0;
            r_active <= 1'b0;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_dwell  <= '0;
            r_down   <= 1'b0;
            r_bounce <= 1'b0;
            r_loop   <= 1'b0;
            r_turned <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; later assignments in
            // this block override these one-cycle strobe defaults.
            r_step <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_code   <= 3'd0;
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                    // stop has priority over a simultaneous start
                    if (bus.start && !bus.stop) begin
                        r_state  <= S_SCAN;
                        r_dwell  <= bus.dwell;
                        r_down   <= bus.dir;
                        r_bounce <= bus.bounce;
                        r_loop   <= bus.loop;
                        r_turned <= 1'b0;
                        r_code   <= bus.dir ? C_LAST : C_FIRST;
                        r_active <= 1'b1;
                        r_step   <= 1'b1;
                    end
                end

                S_SCAN: begin
                    if (bus.stop) begin
                        // Abort: back to idle without a done strobe
                        r_state  <= S_IDLE;
                        r_code   <= 3'd0;
                        r_active <= 1'b0;
                        r_cnt    <= '0;
                    end else if (!w_dwell_done) begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!w_at_end) begin
                            r_code <= r_down ? (r_code - 3'd1) : (r_code + 3'd1);
                            r_step <= 1'b1;
                        end else if (r_bounce && !(r_turned && !r_loop)) begin
                            // Reverse at the range end; the end code is not repeated
                            r_down   <= ~r_down;
                            r_turned <= 1'b1;
                            r_code   <= r_down ? C_FIRST_P1 : C_LAST_M1;
                            r_step   <= 1'b1;
                        end else if (!r_bounce && r_loop) begin
                            r_code <= r_down ? C_LAST : C_FIRST;
                            r_step <= 1'b1;
                        end else begin
                            // Natural end of a single pass
                            r_state  <= S_IDLE;
                            r_code   <= 3'd0;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_code   <= 3'd0;
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.a      = r_code[2];
    assign bus.b      = r_code[1];
    assign bus.c      = r_code[0];
    assign bus.active = r_active;
    assign bus.step   = r_step;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: one full-range instance (0..7)
// and one narrow-range instance (2..5), expected values written by hand.
module tb_decoder_scan_sequencer;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decoder_scan_sequencer_if #(.DWELL_W(DW)) bus_if ();
    decoder_scan_sequencer_if #(.DWELL_W(DW)) bus2_if ();

    decoder_scan_sequencer #(.DWELL_W(DW), .FIRST(0), .LAST(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    decoder_scan_sequencer #(.DWELL_W(DW), .FIRST(2), .LAST(5)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2_if.slave)
    );

    function automatic logic [31:0] b2w(input logic x);
        return {31'd0, x};
    endfunction

    function automatic logic [31:0] abc1();
        return {29'd0, bus_if.a, bus_if.b, bus_if.c};
    endfunction

    function automatic logic [31:0] abc2();
        return {29'd0, bus2_if.a, bus2_if.b, bus2_if.c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.start = 1'b0;  bus_if.stop = 1'b0;  bus_if.dir = 1'b0;
        bus_if.bounce = 1'b0; bus_if.loop = 1'b0;  bus_if.dwell = '0;
        bus2_if.start = 1'b0; bus2_if.stop = 1'b0; bus2_if.dir = 1'b0;
        bus2_if.bounce = 1'b0; bus2_if.loop = 1'b0; bus2_if.dwell = '0;

        // Reset state
        #3;
        check("rst abc",    abc1(), 0);
        check("rst active", b2w(bus_if.active), 0);
        check("rst step",   b2w(bus_if.step), 0);
        check("rst done",   b2w(bus_if.done), 0);
        check("rst abc2",   abc2(), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: dwell 0, up, single pass
        bus_if.dwell = 8'd0; bus_if.dir = 1'b0; bus_if.loop = 1'b0; bus_if.bounce = 1'b0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1 abc[%0d]", i),    abc1(), i);
            check($sformatf("t1 step[%0d]", i),   b2w(bus_if.step), 1);
            check($sformatf("t1 active[%0d]", i), b2w(bus_if.active), 1);
            tick();
        end
        check("t1 end abc",    abc1(), 0);
        check("t1 end done",   b2w(bus_if.done), 1);
        check("t1 end active", b2w(bus_if.active), 0);
        check("t1 end step",   b2w(bus_if.step), 0);
        tick();
        check("t1 done clear", b2w(bus_if.done), 0);

        // 2: dwell 3, up, single pass
        bus_if.dwell = 8'd3;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check($sformatf("t2 abc[%0d]", k),  abc1(), k / 4);
            check($sformatf("t2 step[%0d]", k), b2w(bus_if.step), b2w(k % 4 == 0));
            check($sformatf("t2 done[%0d]", k), b2w(bus_if.done), 0);
            tick();
        end
        check("t2 end done", b2w(bus_if.done), 1);
        check("t2 end abc",  abc1(), 0);
        tick();

        // 3: down, looping, dwell 0; stop while 101 is shown after one wrap
        bus_if.dwell = 8'd0; bus_if.dir = 1'b1; bus_if.loop = 1'b1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t3 abc[%0d]", i),  abc1(), 7 - (i % 8));
            check($sformatf("t3 step[%0d]", i), b2w(bus_if.step), 1);
            if (i < 10) tick();
        end
        bus_if.stop = 1'b1;
        tick();
        bus_if.stop = 1'b0;
        check("t3 stop abc",    abc1(), 0);
        check("t3 stop active", b2w(bus_if.active), 0);
        check("t3 stop done",   b2w(bus_if.done), 0);
        check("t3 stop step",   b2w(bus_if.step), 0);
        tick();
        check("t3 idle active", b2w(bus_if.active), 0);

        // 4: bounce single pass from FIRST: 0..7 then 6..0
        bus_if.dir = 1'b0; bus_if.loop = 1'b0; bus_if.bounce = 1'b1; bus_if.dwell = 8'd0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("t4 abc[%0d]", i),  abc1(), (i <= 7) ? i : 14 - i);
            check($sformatf("t4 step[%0d]", i), b2w(bus_if.step), 1);
            tick();
        end
        check("t4 end done",   b2w(bus_if.done), 1);
        check("t4 end abc",    abc1(), 0);
        check("t4 end active", b2w(bus_if.active), 0);
        tick();

        // 5: asynchronous reset in the middle of code 011's dwell
        bus_if.bounce = 1'b0; bus_if.dwell = 8'd3;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        repeat (13) tick();
        check("t5 pre-rst abc", abc1(), 3);
        rst_n = 1'b0;
        #2;
        check("t5 rst abc",    abc1(), 0);
        check("t5 rst active", b2w(bus_if.active), 0);
        check("t5 rst step",   b2w(bus_if.step), 0);
        check("t5 rst done",   b2w(bus_if.done), 0);
        tick();
        rst_n = 1'b1;
        bus_if.dwell = 8'd0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        check("t5 restart abc",  abc1(), 0);
        check("t5 restart step", b2w(bus_if.step), 1);
        repeat (8) tick();
        check("t5 restart done", b2w(bus_if.done), 1);
        tick();

        // 6a: start and stop together in IDLE
        bus_if.start = 1'b1; bus_if.stop = 1'b1;
        tick();
        bus_if.start = 1'b0; bus_if.stop = 1'b0;
        check("t6a active", b2w(bus_if.active), 0);
        check("t6a step",   b2w(bus_if.step), 0);
        tick();
        check("t6a still idle", b2w(bus_if.active), 0);

        // 6b: start pulse and config changes mid-scan are ignored (dwell 1)
        bus_if.dwell = 8'd1; bus_if.dir = 1'b0; bus_if.loop = 1'b0; bus_if.bounce = 1'b0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t6b abc[%0d]", k),  abc1(), k / 2);
            check($sformatf("t6b step[%0d]", k), b2w(bus_if.step), b2w(k % 2 == 0));
            if (k == 3) begin
                bus_if.start = 1'b1; bus_if.dwell = 8'd5; bus_if.dir = 1'b1; bus_if.bounce = 1'b1;
            end
            if (k == 4) bus_if.start = 1'b0;
            tick();
        end
        check("t6b end done", b2w(bus_if.done), 1);
        check("t6b end abc",  abc1(), 0);

        // 6c: narrow range 2..5, up looping wraps to 010
        check("t6c idle abc2", abc2(), 0);
        bus2_if.dir = 1'b0; bus2_if.loop = 1'b1; bus2_if.bounce = 1'b0; bus2_if.dwell = 8'd0;
        bus2_if.start = 1'b1;
        tick();
        bus2_if.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t6c abc2[%0d]", i), abc2(), 2 + (i % 4));
            tick();
        end
        bus2_if.stop = 1'b1;
        tick();
        bus2_if.stop = 1'b0;
        check("t6c stop abc2",    abc2(), 0);
        check("t6c stop active2", b2w(bus2_if.active), 0);

        // 6d: narrow range, down with bounce looping: 5,4,3,2,3,4,5,4
        bus2_if.dir = 1'b1; bus2_if.bounce = 1'b1;
        bus2_if.start = 1'b1;
        tick();
        bus2_if.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6d abc2[%0d]", i), abc2(), (i <= 3) ? 5 - i : ((i <= 6) ? i - 1 : 4));
            check($sformatf("t6d step2[%0d]", i), b2w(bus2_if.step), 1);
            tick();
        end
        bus2_if.stop = 1'b1;
        tick();
        bus2_if.stop = 1'b0;
        check("t6d stop active2", b2w(bus2_if.active), 0);
        check("t6d stop done2",   b2w(bus2_if.done), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
